i2s_serializer: RTL and testbench

//  Output stage of the I2S playback path: accepts 24-bit samples from the memory controller via audio_data_request/ack.

---
 rtl/i2s_serializer_pkg.sv | 15 +
 rtl/i2s_serializer.sv | 128 ++++++++++++
 tb/tb_i2s_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_serializer_pkg.sv
// Shared constants and types for the I2S playback output stage.
package i2s_serializer_pkg;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;

  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_serializer.sv
// I2S output stage: one-deep sample prefetch, MSB-first shifter with I2S one-bit
// word-select lead, zero-fill and starved flag when no sample matches the slot.
module i2s_serializer
  import i2s_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  i2s_clock,
  output logic                  audio_data_request,
  input  logic                  audio_data_ack,
  input  logic [DATA_WIDTH-1:0] audio_data,
  input  logic                  audio_lr_bit,
  output logic                  starved,
  output logic                  i2s_data,
  output logic                  i2s_lr
);

  localparam int              CNT_W    = $clog2(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_WIDTH - 1);

  state_e                  state_q, state_d;
  logic                    bclk_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_next;
  logic                    lr_q, lr_d;
  logic [SLOT_WIDTH-1:0]   shift_q, shift_d;
  logic                    data_q, data_d;
  logic                    starved_q, starved_d;
  logic                    req_q, req_d;
  logic                    pf_valid_q, pf_valid_d;
  logic [DATA_WIDTH-1:0]   pf_data_q, pf_data_d;
  logic                    pf_lr_q, pf_lr_d;
  logic                    fall;

  assign fall     = bclk_q & ~i2s_clock;
  assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  // NOTE: every target gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lr_d       = lr_q;
    shift_d    = shift_q;
    data_d     = data_q;
    starved_d  = starved_q;
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
    pf_lr_d    = pf_lr_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = CNT_LAST;
      lr_d       = I2S_CH_LEFT;
      shift_d    = '0;
      data_d     = 1'b0;
      starved_d  = 1'b0;
      pf_valid_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end else begin
      if (fall) begin
        cnt_d = cnt_next;
        if (cnt_next == CNT_LAST) begin
          lr_d = (lr_q == I2S_CH_LEFT) ? I2S_CH_RIGHT : I2S_CH_LEFT;
        end
        if (cnt_next == '0) begin
          // Slot start: a held sample for the other channel waits for its own slot.
          shift_d = '0;
          if (pf_valid_q && (pf_lr_q == lr_q)) begin
            shift_d[SLOT_WIDTH-1 -: DATA_WIDTH] = pf_data_q;
            pf_valid_d = 1'b0;
            starved_d  = 1'b0;
          end else begin
            starved_d = ~pf_valid_q;
          end
        end else begin
          shift_d = {shift_q[SLOT_WIDTH-2:0], 1'b0};
        end
        data_d = shift_d[SLOT_WIDTH-1];
      end
      if (audio_data_ack && req_q) begin
        pf_valid_d = 1'b1;
        pf_data_d  = audio_data;
        pf_lr_d    = audio_lr_bit;
      end
    end

    req_d = (state_d == ST_RUN) && !pf_valid_d;
  end

  // NOTE: state registers use non-blocking assignment so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bclk_q     <= 1'b0;
      cnt_q      <= CNT_LAST;
      lr_q       <= I2S_CH_LEFT;
      shift_q    <= '0;
      data_q     <= 1'b0;
      starved_q  <= 1'b0;
      req_q      <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_data_q  <= '0;
      pf_lr_q    <= I2S_CH_LEFT;
    end else begin
      state_q    <= state_d;
      bclk_q     <= i2s_clock;
      cnt_q      <= cnt_d;
      lr_q       <= lr_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      starved_q  <= starved_d;
      req_q      <= req_d;
      pf_valid_q <= pf_valid_d;
      pf_data_q  <= pf_data_d;
      pf_lr_q    <= pf_lr_d;
    end
  end

  assign audio_data_request = req_q;
  assign starved            = starved_q;
  assign i2s_data           = data_q;
  assign i2s_lr             = lr_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: expected slots are queued as stimulus is
// driven and compared as the serial stream is reassembled on bit clock rises.
module tb_i2s_serializer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        i2s_clock;
  logic        audio_data_request;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;
  logic        starved;
  logic        i2s_data;
  logic        i2s_lr;

  typedef struct packed {
    logic        lr;
    logic [23:0] data;
    logic        starved;
  } exp_t;

  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  logic        mon_en = 1'b0;
  int          bidx   = -1;
  logic        prev_bclk = 1'b0;
  logic [31:0] acc    = '0;
  logic        s0     = 1'b0;
  int          pos;
  logic        exp_lr;
  exp_t        popped;

  i2s_serializer dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .i2s_clock          (i2s_clock),
    .audio_data_request (audio_data_request),
    .audio_data_ack     (audio_data_ack),
    .audio_data         (audio_data),
    .audio_lr_bit       (audio_lr_bit),
    .starved            (starved),
    .i2s_data           (i2s_data),
    .i2s_lr             (i2s_lr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit clock: 8 clk periods, edges placed just after a clk rising edge.
  initial begin
    i2s_clock = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 i2s_clock = ~i2s_clock;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic lr, input logic [23:0] d, input logic st);
    exp_t e;
    e.lr      = lr;
    e.data    = d;
    e.starved = st;
    sb.push_back(e);
  endtask

  // Reassemble slots: falls advance the bit index, rises sample mid-bit.
  always @(negedge clk) begin
    if (!mon_en) begin
      bidx      = -1;
      prev_bclk = i2s_clock;
    end else begin
      if (prev_bclk && !i2s_clock) begin
        bidx++;
      end else if (!prev_bclk && i2s_clock && bidx >= 0) begin
        pos = bidx % 32;
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_lr = (pos == 31) ? ~sb[0].lr : sb[0].lr;
          check("lr", {31'd0, i2s_lr}, {31'd0, exp_lr});
        end
        acc = {acc[30:0], i2s_data};
        if (pos == 0) s0 = starved;
        if (pos == 31 && sb.size() != 0) begin
          popped = sb.pop_front();
          check("slot_data", acc, {popped.data, 8'h00});
          check("starved_start", {31'd0, s0}, {31'd0, popped.starved});
          check("starved_end", {31'd0, starved}, {31'd0, popped.starved});
        end
      end
      prev_bclk = i2s_clock;
    end
  end

  task automatic wait_pos(input int slot, input int p);
    int target = slot * 32 + p;
    int n = 0;
    while (bidx != target && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_pos", bidx, target);
  endtask

  task automatic start_run();
    @(posedge i2s_clock);
    enable = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic do_ack(input logic [23:0] d, input logic lr);
    int n = 0;
    @(negedge clk);
    while (audio_data_request !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("req_before_ack", {31'd0, audio_data_request}, 32'd1);
    @(posedge clk);
    #1;
    audio_data     = d;
    audio_lr_bit   = lr;
    audio_data_ack = 1'b1;
    @(posedge clk);
    #1;
    audio_data_ack = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_data"}, {31'd0, i2s_data}, 32'd0);
    check({pfx, "_lr"}, {31'd0, i2s_lr}, 32'd0);
    check({pfx, "_starved"}, {31'd0, starved}, 32'd0);
    check({pfx, "_req"}, {31'd0, audio_data_request}, 32'd0);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    enable         = 1'b0;
    audio_data_ack = 1'b0;
    audio_data     = '0;
    audio_lr_bit   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Run A: normal L/R pair, sample ready before the first slot.
    start_run();
    push(1'b0, 24'hA5A5A5, 1'b0);
    do_ack(24'hA5A5A5, 1'b0);
    push(1'b1, 24'h5A5A5A, 1'b0);
    do_ack(24'h5A5A5A, 1'b1);

    // Right sample held across a left slot start: realignment zeros, not starved.
    wait_pos(1, 4);
    push(1'b0, 24'h000000, 1'b0);
    push(1'b1, 24'h3C3C3C, 1'b0);
    do_ack(24'h3C3C3C, 1'b1);

    // Ack while request is low must not overwrite the held sample.
    wait_pos(3, 4);
    push(1'b0, 24'h123456, 1'b0);
    do_ack(24'h123456, 1'b0);
    wait_pos(3, 10);
    check("req_low_when_full", {31'd0, audio_data_request}, 32'd0);
    audio_data     = 24'hFFFFFF;
    audio_lr_bit   = 1'b0;
    audio_data_ack = 1'b1;
    @(posedge clk);
    #1 audio_data_ack = 1'b0;

    // Ack on the very clk of a slot-start fall with prefetch empty.
    push(1'b1, 24'h000000, 1'b1);
    push(1'b0, 24'h000000, 1'b0);
    push(1'b1, 24'h0F0F0F, 1'b0);
    wait_pos(5, 0);
    check("req_at_slot_start", {31'd0, audio_data_request}, 32'd1);
    audio_data     = 24'h0F0F0F;
    audio_lr_bit   = 1'b1;
    audio_data_ack = 1'b1;
    @(posedge clk);
    #1 audio_data_ack = 1'b0;

    // Underrun on both channels, then recovery on the next left slot.
    push(1'b0, 24'h000000, 1'b1);
    push(1'b1, 24'h000000, 1'b1);
    wait_pos(9, 4);
    check("req_held_starved", {31'd0, audio_data_request}, 32'd1);
    push(1'b0, 24'h800001, 1'b0);
    do_ack(24'h800001, 1'b0);
    push(1'b1, 24'h000000, 1'b1);

    // Drop enable mid-slot at bit_count 10.
    wait_pos(11, 10);
    @(posedge clk);
    #1;
    enable = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("disable");
    sb.delete();
    repeat (5) @(posedge clk);

    // Run B: clean restart, then synchronous reset mid-slot.
    start_run();
    push(1'b0, 24'h654321, 1'b0);
    do_ack(24'h654321, 1'b0);
    push(1'b1, 24'h0ABCDE, 1'b0);
    do_ack(24'h0ABCDE, 1'b1);
    push(1'b0, 24'h000000, 1'b1);
    wait_pos(2, 10);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b0;
    sb.delete();
    repeat (5) @(posedge clk);

    // Run C: must match run B after the reset.
    start_run();
    push(1'b0, 24'h654321, 1'b0);
    do_ack(24'h654321, 1'b0);
    push(1'b1, 24'h0ABCDE, 1'b0);
    do_ack(24'h0ABCDE, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 32'd0);
    enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
